// File: rtl/exec_stage_md_pkg.sv
// Shared types for the execute stage: ALU ops, M-extension ops, branch codes,
// mul/div FSM states and forwarding selects, plus operand-signedness helpers.
// Build option FAST_MUL_EN (see exec_stage_md) does not change anything here.
package exec_stage_md_pkg;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9,
      ALU_PASS = 4'd10
   } aluop_type_e;

   // funct3 encoding of the RV32M instructions
   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_e;

   localparam logic [2:0] BR_EQ  = 3'b000;
   localparam logic [2:0] BR_NE  = 3'b001;
   localparam logic [2:0] BR_LT  = 3'b100;
   localparam logic [2:0] BR_GE  = 3'b101;
   localparam logic [2:0] BR_LTU = 3'b110;
   localparam logic [2:0] BR_GEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } md_state_e;

   typedef enum logic [1:0] {
      FWD_RF   = 2'b00,
      FWD_E2M  = 2'b01,
      FWD_WB   = 2'b10,
      FWD_RF_X = 2'b11
   } fwd_sel_e;

   function automatic logic is_div(input md_op_e op);
      return op[2];
   endfunction

   // rs1 is treated as signed for MUL, MULH, MULHSU, DIV, REM
   function automatic logic a_signed(input md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is treated as signed for MUL, MULH, DIV, REM
   function automatic logic b_signed(input md_op_e op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/exec_stage_md_muldiv_iter.sv
// Iterative RV32M multiply/divide: magnitudes in, one bit per cycle, sign fix at the end.
// Latency: accept cycle + MD_CYCLES CALC cycles + one DONE cycle carrying the result.
// busy is high in the accept cycle and through CALC; flush or rst abandons the operation.
module muldiv_iter
   import exec_stage_md_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MD_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  md_op_e           op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   localparam int CW = $clog2(MD_CYCLES);

   md_state_e          state, state_nx;
   logic [CW-1:0]      cnt;
   md_op_e             op_q;
   logic [WIDTH-1:0]   opnd;       // multiplicand or divisor magnitude
   logic [2*WIDTH-1:0] acc;        // {hi, lo}: product, or {remainder, quotient}
   logic               neg_q;      // negate product / quotient at the end
   logic               neg_r;      // negate remainder at the end
   logic               b_zero;     // divisor was zero

   logic               sgn_a, sgn_b;
   logic [WIDTH-1:0]   mag_a, mag_b;
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] mul_nx;
   logic [WIDTH:0]     div_trial, div_diff;
   logic [2*WIDTH-1:0] div_nx;

   // Operand magnitudes according to the signedness of the requested op
   always_comb begin
      sgn_a = a_signed(op) & a[WIDTH-1];
      sgn_b = b_signed(op) & b[WIDTH-1];
      mag_a = sgn_a ? -a : a;
      mag_b = sgn_b ? -b : b;
   end

   // One shift-add step and one restoring-division step, selected in the register
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
      mul_nx    = {mul_sum, acc[WIDTH-1:1]};
      div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_trial - {1'b0, opnd};
      if (div_diff[WIDTH])
         div_nx = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else
         div_nx = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = CALC;
               busy     = 1'b1;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (cnt == '0)
               state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (flush)
         state_nx = IDLE;
   end

   // State, operand latch and iteration registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         op_q   <= MD_MUL;
         opnd   <= '0;
         acc    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start && !flush) begin
            op_q   <= op;
            cnt    <= CW'(MD_CYCLES - 1);
            b_zero <= (b == '0);
            neg_q  <= sgn_a ^ sgn_b;
            neg_r  <= sgn_a;
            if (is_div(op)) begin
               opnd <= mag_b;
               acc  <= {{WIDTH{1'b0}}, mag_a};
            end else begin
               opnd <= mag_a;
               acc  <= {{WIDTH{1'b0}}, mag_b};
            end
         end else if (state == CALC) begin
            cnt <= cnt - 1'b1;
            acc <= is_div(op_q) ? div_nx : mul_nx;
         end
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo, rem;

   // Sign correction and result selection; the divide-by-zero quotient is forced,
   // while the overflow case falls out of the magnitude arithmetic naturally
   always_comb begin
      prod = neg_q ? -acc : acc;
      quo  = b_zero ? '1 : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      case (op_q)
         MD_MUL:                        result = prod[WIDTH-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  result = prod[2*WIDTH-1:WIDTH];
         MD_DIV, MD_DIVU:               result = quo;
         default:                       result = rem;
      endcase
   end

endmodule

// File: rtl/exec_stage_md.sv
// Execute stage: operand forwarding, ALU, branch compare and RV32M mul/div with stall.
// Latency: ALU/branch combinational; mul/div WIDTH+2 cycles (FAST_MUL_EN: multiplies 0).
// md_busy freezes IF/ID/EX while the iterative unit works; flush drops it next edge.
module exec_stage_md
   import exec_stage_md_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int MD_CYCLES = WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic             flush,
   input  logic [WIDTH-1:0] pc_addr,
   input  logic [WIDTH-1:0] rdata1,
   input  logic [WIDTH-1:0] rdata2,
   input  logic [WIDTH-1:0] imm,
   input  logic             sel_a,
   input  logic             sel_b,
   input  logic [1:0]       forward_ae,
   input  logic [1:0]       forward_be,
   input  logic [WIDTH-1:0] alu_e2m,
   input  logic [WIDTH-1:0] wb_data,
   input  aluop_type_e      alu_op,
   input  logic             md_req,
   input  logic [2:0]       md_op,
   input  logic [2:0]       br_type,
   output logic [WIDTH-1:0] for_a,
   output logic [WIDTH-1:0] for_b,
   output logic [WIDTH-1:0] result,
   output logic             br_taken,
   output logic             md_busy
);

   localparam int SHW = $clog2(WIDTH);

   logic [WIDTH-1:0] fwd_a, fwd_b, src_a, src_b, alu_res;
   logic [SHW-1:0]   shamt;
   md_op_e           mop;

   assign mop = md_op_e'(md_op);

   // Forwarding muxes; the unused code 11 reads the register file
   always_comb begin
      case (fwd_sel_e'(forward_ae))
         FWD_E2M: fwd_a = alu_e2m;
         FWD_WB:  fwd_a = wb_data;
         default: fwd_a = rdata1;
      endcase
      case (fwd_sel_e'(forward_be))
         FWD_E2M: fwd_b = alu_e2m;
         FWD_WB:  fwd_b = wb_data;
         default: fwd_b = rdata2;
      endcase
      src_a = sel_a ? pc_addr : fwd_a;
      src_b = sel_b ? imm : fwd_b;
      shamt = src_b[SHW-1:0];
   end

   assign for_a = fwd_a;
   assign for_b = fwd_b;

   // Single-cycle ALU; unknown opcodes yield zero
   always_comb begin
      case (alu_op)
         ALU_ADD:  alu_res = src_a + src_b;
         ALU_SUB:  alu_res = src_a - src_b;
         ALU_SLL:  alu_res = src_a << shamt;
         ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
         ALU_XOR:  alu_res = src_a ^ src_b;
         ALU_SRL:  alu_res = src_a >> shamt;
         ALU_SRA:  alu_res = $signed(src_a) >>> shamt;
         ALU_OR:   alu_res = src_a | src_b;
         ALU_AND:  alu_res = src_a & src_b;
         ALU_PASS: alu_res = src_b;
         default:  alu_res = '0;
      endcase
   end

   // Branch comparator on the forwarded register operands
   always_comb begin
      case (br_type)
         BR_EQ:   br_taken = (fwd_a == fwd_b);
         BR_NE:   br_taken = (fwd_a != fwd_b);
         BR_LT:   br_taken = ($signed(fwd_a) <  $signed(fwd_b));
         BR_GE:   br_taken = ($signed(fwd_a) >= $signed(fwd_b));
         BR_LTU:  br_taken = (fwd_a <  fwd_b);
         BR_GEU:  br_taken = (fwd_a >= fwd_b);
         default: br_taken = 1'b0;
      endcase
      if (!valid_i)
         br_taken = 1'b0;
   end

   logic             fast_mul;
   logic [WIDTH-1:0] fast_res;

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a, ext_b, fast_prod;

   // Single-cycle multiplier: sign/zero-extend to 2*WIDTH and keep the low product
   always_comb begin
      fast_mul  = !is_div(mop);
      ext_a     = {{WIDTH{a_signed(mop) & fwd_a[WIDTH-1]}}, fwd_a};
      ext_b     = {{WIDTH{b_signed(mop) & fwd_b[WIDTH-1]}}, fwd_b};
      fast_prod = ext_a * ext_b;
      fast_res  = (mop == MD_MUL) ? fast_prod[WIDTH-1:0] : fast_prod[2*WIDTH-1:WIDTH];
   end
`else
   assign fast_mul = 1'b0;
   assign fast_res = '0;
`endif

   logic             md_start, md_done;
   logic [WIDTH-1:0] md_res;

   // rst also gates the accept so the stall drops the moment reset is applied
   assign md_start = valid_i & md_req & ~flush & ~rst & ~fast_mul;

   muldiv_iter #(
      .WIDTH     (WIDTH),
      .MD_CYCLES (MD_CYCLES)
   ) u_muldiv (
      .clk    (clk),
      .rst    (rst),
      .start  (md_start),
      .op     (mop),
      .a      (fwd_a),
      .b      (fwd_b),
      .flush  (flush),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_res)
   );

   // Result select; an iterative op shows zero until DONE since it is not captured
   always_comb begin
      if (md_req) begin
         if (fast_mul)
            result = fast_res;
         else
            result = md_done ? md_res : '0;
      end else begin
         result = alu_res;
      end
   end

endmodule

// File: tb/tb_exec_stage_md.sv
// Self-checking bench for exec_stage_md (default WIDTH = 32).
// Random and directed stimulus against a behavioural arithmetic reference model.
// Honours FAST_MUL_EN when the build defines it.
module tb_exec_stage_md;
   import exec_stage_md_pkg::*;

   localparam int W = 32;
`ifdef FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic          clk, rst, valid_i, flush, sel_a, sel_b, md_req;
   logic [W-1:0]  pc_addr, rdata1, rdata2, imm, alu_e2m, wb_data;
   logic [1:0]    forward_ae, forward_be;
   aluop_type_e   alu_op;
   logic [2:0]    md_op, br_type;
   logic [W-1:0]  for_a, for_b, result;
   logic          br_taken, md_busy;

   int tests_run = 0;
   int fails     = 0;

   exec_stage_md #(.WIDTH(W), .MD_CYCLES(W)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .flush(flush), .pc_addr(pc_addr),
      .rdata1(rdata1), .rdata2(rdata2), .imm(imm), .sel_a(sel_a), .sel_b(sel_b),
      .forward_ae(forward_ae), .forward_be(forward_be), .alu_e2m(alu_e2m),
      .wb_data(wb_data), .alu_op(alu_op), .md_req(md_req), .md_op(md_op),
      .br_type(br_type), .for_a(for_a), .for_b(for_b), .result(result),
      .br_taken(br_taken), .md_busy(md_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] fwd_m(input logic [1:0] s, input logic [W-1:0] rd,
                                          input logic [W-1:0] e2m, input logic [W-1:0] wb);
      if (s == 2'b01) return e2m;
      if (s == 2'b10) return wb;
      return rd;
   endfunction

   function automatic logic [W-1:0] alu_m(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      int sh;
      sh = int'(b % W);
      case (op)
         0:  return a + b;
         1:  return a - b;
         2:  return a << sh;
         3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4:  return (a < b) ? 32'd1 : 32'd0;
         5:  return a ^ b;
         6:  return a >> sh;
         7:  return $unsigned($signed(a) >>> sh);
         8:  return a | b;
         9:  return a & b;
         10: return b;
         default: return '0;
      endcase
   endfunction

   function automatic logic br_m(input logic v, input logic [2:0] t, input logic [W-1:0] a, input logic [W-1:0] b);
      if (!v) return 1'b0;
      case (t)
         3'b000: return a == b;
         3'b001: return a != b;
         3'b100: return $signed(a) < $signed(b);
         3'b101: return $signed(a) >= $signed(b);
         3'b110: return a < b;
         3'b111: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [W-1:0] md_m(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb, ua, ub, p;
      logic ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'({32'd0, a});
      ub  = longint'({32'd0, b});
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         0: begin p = sa * sb; return p[31:0];  end
         1: begin p = sa * sb; return p[63:32]; end
         2: begin p = sa * ub; return p[63:32]; end
         3: begin p = ua * ub; return p[63:32]; end
         4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf)    return a;
            p = sa / sb; return p[31:0];
         end
         5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         6: begin
            if (b == 0) return a;
            if (ovf)    return '0;
            p = sa % sb; return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [W-1:0] rnd_operand();
      case ($urandom_range(0, 5))
         0: return '0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return W'($urandom_range(0, 20));
         default: return W'($urandom);
      endcase
   endfunction

   function automatic int exp_busy(input int op);
      return (FAST && op < 4) ? 0 : W + 1;
   endfunction

   // Runs one mul/div instruction starting just after a rising edge; ends just after
   // the edge that retires it. Operands are scrambled while busy.
   task automatic run_md(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] res, output int busy_n, output bit got);
      valid_i = 1'b1; md_req = 1'b1; md_op = 3'(op);
      rdata1 = a; rdata2 = b; forward_ae = 2'b00; forward_be = 2'b00;
      sel_a = 1'b0; sel_b = 1'b0; flush = 1'b0;
      busy_n = 0; got = 1'b0; res = '0;
      for (int k = 0; k < 200 && !got; k++) begin
         @(negedge clk);
         if (md_busy) begin
            busy_n++;
            @(posedge clk); #1;
            rdata1 = $urandom; rdata2 = $urandom;
         end else begin
            res = result; got = 1'b1;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle_inputs();
      valid_i = 1'b0; md_req = 1'b0; flush = 1'b0; md_op = '0; br_type = 3'b010;
      sel_a = 1'b0; sel_b = 1'b0; forward_ae = '0; forward_be = '0;
      alu_op = ALU_ADD;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      idle_inputs();
      pc_addr = '0; imm = '0; alu_e2m = '0; wb_data = '0;
      rdata1 = 32'd5; rdata2 = 32'd9;
      rst = 1'b1;
      #12;
      @(negedge clk);
      tests_run++;
      if (md_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", md_busy); end
      tests_run++;
      if (result !== 32'd14) begin fails++; $display("FAIL reset_result got %h want %h", result, 32'd14); end
      tests_run++;
      if (br_taken !== 1'b0) begin fails++; $display("FAIL reset_br got %b want 0", br_taken); end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_forward();
      idle_inputs();
      valid_i = 1'b1; forward_ae = 2'b10; wb_data = 32'd5; rdata1 = 32'd77;
      rdata2 = 32'd3; alu_op = ALU_SUB;
      @(negedge clk);
      tests_run++;
      if (result !== 32'd2) begin fails++; $display("FAIL fwd_sub got %h want 2", result); end
      tests_run++;
      if (md_busy !== 1'b0) begin fails++; $display("FAIL fwd_sub_busy got %b want 0", md_busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_alu_random();
      logic [W-1:0] fa, fb, sa, sb;
      int op;
      for (int i = 0; i < 60; i++) begin
         idle_inputs();
         valid_i = 1'($urandom); op = $urandom_range(0, 15);
         alu_op = aluop_type_e'(4'(op));
         sel_a = 1'($urandom); sel_b = 1'($urandom);
         forward_ae = 2'($urandom); forward_be = 2'($urandom);
         br_type = 3'($urandom);
         pc_addr = rnd_operand(); imm = rnd_operand(); rdata1 = rnd_operand();
         rdata2 = rnd_operand(); alu_e2m = rnd_operand(); wb_data = rnd_operand();
         if ($urandom_range(0, 3) == 0) rdata2 = rdata1;
         fa = fwd_m(forward_ae, rdata1, alu_e2m, wb_data);
         fb = fwd_m(forward_be, rdata2, alu_e2m, wb_data);
         sa = sel_a ? pc_addr : fa;
         sb = sel_b ? imm : fb;
         @(negedge clk);
         tests_run++;
         if (result !== alu_m(op, sa, sb)) begin
            fails++; $display("FAIL alu op=%0d got %h want %h", op, result, alu_m(op, sa, sb));
         end
         tests_run++;
         if (for_a !== fa || for_b !== fb) begin
            fails++; $display("FAIL fwd_ops got %h/%h want %h/%h", for_a, for_b, fa, fb);
         end
         tests_run++;
         if (br_taken !== br_m(valid_i, br_type, fa, fb)) begin
            fails++; $display("FAIL branch type=%b got %b want %b", br_type, br_taken, br_m(valid_i, br_type, fa, fb));
         end
         tests_run++;
         if (md_busy !== 1'b0) begin fails++; $display("FAIL alu_busy got %b want 0", md_busy); end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_branch();
      logic [2:0] types [3];
      logic       vals  [3];
      logic       exps  [3];
      types[0] = 3'b100; vals[0] = 1'b1; exps[0] = 1'b1;
      types[1] = 3'b110; vals[1] = 1'b1; exps[1] = 1'b0;
      types[2] = 3'b100; vals[2] = 1'b0; exps[2] = 1'b0;
      for (int i = 0; i < 3; i++) begin
         idle_inputs();
         rdata1 = 32'hFFFF_FFFF; rdata2 = 32'd1;
         br_type = types[i]; valid_i = vals[i];
         @(negedge clk);
         tests_run++;
         if (br_taken !== exps[i]) begin
            fails++; $display("FAIL branch_dir%0d got %b want %b", i, br_taken, exps[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_muldiv_directed();
      int           ops [9];
      logic [W-1:0] as  [9];
      logic [W-1:0] bs  [9];
      logic [W-1:0] exs [9];
      logic [W-1:0] r;
      int           bn;
      bit           got;
      ops[0] = 0; as[0] = 32'hFFFF_FFFE; bs[0] = 32'd3;          exs[0] = 32'hFFFF_FFFA;
      ops[1] = 1; as[1] = 32'hFFFF_FFFE; bs[1] = 32'd3;          exs[1] = 32'hFFFF_FFFF;
      ops[2] = 3; as[2] = 32'hFFFF_FFFE; bs[2] = 32'd3;          exs[2] = 32'h0000_0002;
      ops[3] = 4; as[3] = 32'd7;         bs[3] = 32'd0;          exs[3] = 32'hFFFF_FFFF;
      ops[4] = 6; as[4] = 32'd7;         bs[4] = 32'd0;          exs[4] = 32'd7;
      ops[5] = 4; as[5] = 32'h8000_0000; bs[5] = 32'hFFFF_FFFF;  exs[5] = 32'h8000_0000;
      ops[6] = 6; as[6] = 32'h8000_0000; bs[6] = 32'hFFFF_FFFF;  exs[6] = 32'd0;
      ops[7] = 4; as[7] = 32'hFFFF_FFF9; bs[7] = 32'd2;          exs[7] = 32'hFFFF_FFFD;
      ops[8] = 6; as[8] = 32'hFFFF_FFF9; bs[8] = 32'd2;          exs[8] = 32'hFFFF_FFFF;
      for (int i = 0; i < 9; i++) begin
         idle_inputs();
         @(posedge clk); #1;
         run_md(ops[i], as[i], bs[i], r, bn, got);
         tests_run++;
         if (!got) begin fails++; $display("FAIL md_dir%0d timeout", i); end
         tests_run++;
         if (r !== exs[i]) begin fails++; $display("FAIL md_dir%0d op=%0d got %h want %h", i, ops[i], r, exs[i]); end
         tests_run++;
         if (bn != exp_busy(ops[i])) begin fails++; $display("FAIL md_dir%0d_busy got %0d want %0d", i, bn, exp_busy(ops[i])); end
      end
      idle_inputs();
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a, b, r;
      int           op, bn;
      bit           got;
      idle_inputs();
      @(posedge clk); #1;
      for (int i = 0; i < 24; i++) begin
         op = $urandom_range(0, 7); a = rnd_operand(); b = rnd_operand();
         run_md(op, a, b, r, bn, got);
         tests_run++;
         if (!got || r !== md_m(op, a, b)) begin
            fails++; $display("FAIL b2b op=%0d a=%h b=%h got %h want %h", op, a, b, r, md_m(op, a, b));
         end
         tests_run++;
         if (bn != exp_busy(op)) begin fails++; $display("FAIL b2b_busy op=%0d got %0d want %0d", op, bn, exp_busy(op)); end
      end
      idle_inputs();
   endtask

   task automatic test_flush();
      logic [W-1:0] r;
      int           bn;
      bit           got;
      idle_inputs();
      @(posedge clk); #1;
      valid_i = 1'b1; md_req = 1'b1; md_op = 3'(MD_DIVU); rdata1 = 32'd1000; rdata2 = 32'd3;
      @(posedge clk); #1;               // accepted, CALC cycle 1
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;                     // CALC cycle 10
      @(negedge clk);
      tests_run++;
      if (md_busy !== 1'b1) begin fails++; $display("FAIL flush_pre_busy got %b want 1", md_busy); end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      tests_run++;
      if (md_busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %b want 0", md_busy); end
      @(posedge clk); #1;
      run_md(5, 32'd100, 32'd7, r, bn, got);
      tests_run++;
      if (!got || r !== 32'd14) begin fails++; $display("FAIL flush_divu got %h want %h", r, 32'd14); end
      tests_run++;
      if (bn != W + 1) begin fails++; $display("FAIL flush_divu_busy got %0d want %0d", bn, W + 1); end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] r;
      int           bn;
      bit           got;
      idle_inputs();
      @(posedge clk); #1;
      valid_i = 1'b1; md_req = 1'b1; md_op = 3'(MD_REMU); rdata1 = 32'd50; rdata2 = 32'd9;
      repeat (6) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      tests_run++;
      if (md_busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", md_busy); end
      @(posedge clk); #1;
      idle_inputs();
      rst = 1'b0;
      @(posedge clk); #1;
      run_md(7, 32'd50, 32'd9, r, bn, got);
      tests_run++;
      if (!got || r !== 32'd5) begin fails++; $display("FAIL rst_mid_remu got %h want %h", r, 32'd5); end
      tests_run++;
      if (bn != W + 1) begin fails++; $display("FAIL rst_mid_busy_n got %0d want %0d", bn, W + 1); end
      idle_inputs();
   endtask

   task automatic test_fast_mul();
      logic [W-1:0] r;
      int           bn;
      bit           got;
      idle_inputs();
      @(posedge clk); #1;
      run_md(0, 32'd6, 32'd7, r, bn, got);
      tests_run++;
      if (!got || r !== 32'd42) begin fails++; $display("FAIL mul_6x7 got %h want %h", r, 32'd42); end
      tests_run++;
      if (bn != exp_busy(0)) begin fails++; $display("FAIL mul_6x7_busy got %0d want %0d", bn, exp_busy(0)); end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_forward();
      test_branch();
      test_alu_random();
      test_muldiv_directed();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      test_fast_mul();
      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/exec_stage_md.md
Name: exec_stage_md

Overview:
- Parametrised next-generation execute stage for the 5-stage pipeline.
- Contains:
  - Two-source operand forwarding (E/M and M/W).
  - Single-cycle ALU.
  - Branch comparator.
  - Iterative multi-cycle multiply/divide unit (RV32M semantics) with a stall handshake to the hazard unit.
- Sits between the ID/EX and EX/MEM pipeline registers. Drives the EX/MEM register inputs and the pipeline stall.

Parameters:
- WIDTH, 32: datapath width; must be even and ≥8.
- MD_CYCLES, WIDTH: iteration cycles per mul/div; fixed equal to WIDTH (one bit per cycle). Exposed for the hazard unit's bookkeeping only.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- valid_i  in  1  ID/EX holds a live instruction
- flush  in  1  kill the in-flight instruction (branch/jump redirect)
- pc_addr  in  WIDTH  PC of the instruction
- rdata1, rdata2  in  WIDTH  register-file read data
- imm  in  WIDTH  immediate
- sel_a  in  1  src_a = pc_addr when 1, else fwd_a
- sel_b  in  1  src_b = imm when 1, else fwd_b
- forward_ae, forward_be  in  2  00 = rdata, 01 = alu_e2m, 10 = wb_data, 11 = rdata
- alu_e2m  in  WIDTH  EX/MEM result
- wb_data  in  WIDTH  write-back result
- alu_op  in  aluop_type_e  ALU operation
- md_req  in  1  instruction is an M-extension op
- md_op  in  3  funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- br_type  in  3  funct3 branch type; any value not listed under Branch → no branch
- for_a, for_b  out  WIDTH  forwarded operands (for_b feeds the store data path)
- result  out  WIDTH  ALU or mul/div result
- br_taken  out  1  branch condition true
- md_busy  out  1  stall request: freeze IF/ID/EX, bubble into MEM

Behaviour:
- Reset, asynchronous while rst = 1:
  - FSM goes to IDLE.
  - Operand, accumulator and counter registers clear to 0.
  - md_busy = 0.
  - result/br_taken are combinational and follow inputs.
- Forwarding: for_a/for_b decode as listed under Ports. Code 11 is treated as 00.
- ALU: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS.
  - Shift amount is src_b[$clog2(WIDTH)-1:0].
  - SLT compares signed; SLTU compares unsigned.
  - Undefined alu_op → result 0 (no latch).
- Branch (compares fwd operands):
  - 000 eq, 001 ne.
  - 100 lt signed, 101 ge signed.
  - 110 ltu, 111 geu.
  - Any other value → 0.
  - br_taken is forced 0 when valid_i = 0.
- Mul/div FSM states: IDLE, CALC, DONE.
  - IDLE → CALC when valid_i & md_req & !flush.
    - Latch magnitudes of fwd_a/fwd_b per signedness of md_op, plus the result-sign flag.
    - Counter loads WIDTH-1.
    - md_busy = 1 combinationally in this cycle.
  - CALC:
    - Multiply: shift-add, one bit per cycle into a 2·WIDTH accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - md_busy = 1.
    - Counter 0 → DONE.
  - DONE:
    - Apply sign correction.
    - result = selected half/quotient/remainder.
    - md_busy = 0 so the pipeline advances exactly one instruction.
    - Next state IDLE.
  - Total: instruction occupies EX for WIDTH+2 cycles (accept, WIDTH CALC, DONE).
  - While md_req & FSM ≠ DONE, result is don't-care and is not captured (stall).
- Divide edge cases (RV32M):
  - Divide by 0: quotient = all-ones, remainder = dividend.
  - Signed overflow (most-negative / −1): quotient = most-negative, remainder = 0.
  - Both resolve in DONE with the same latency (no early-out).
- Upper halves:
  - MULH: signed × signed.
  - MULHSU: signed rs1 × unsigned rs2.
  - MULHU: unsigned × unsigned.
  - All return product[2·WIDTH-1:WIDTH].
- Flush: in any state, next clock → IDLE, md_busy = 0 on that edge, partial result discarded.
- Operand stability: fwd inputs may change during CALC; only latched values are used.
- Back-to-back md ops: DONE → IDLE, then a new accept. There is no DONE → CALC shortcut.
- Non-md instruction: result = ALU output in the same cycle, md_busy = 0.

Optional Feature:
- FAST_MUL_EN
- Defined:
  - MUL/MULH/MULHSU/MULHU compute combinationally from fwd operands in one cycle.
  - md_busy is never asserted for multiplies; FSM is bypassed.
  - Divides remain iterative.
- Undefined: all M ops use the iterative path as above.

Decomposition:
- pipeline package (existing pipeline_hdrs):
  - aluop_type_e (existing).
  - New md_op_e with the eight funct3 values.
  - br_type localparams BR_EQ … BR_GEU.
  - md_state_e {IDLE, CALC, DONE}.
  - Forwarding select enum fwd_sel_e.
- One sub-module, muldiv_iter: owns the FSM, counter, accumulator and sign handling. Interface: start, op, a, b, flush, busy, done, result.
- ALU, forwarding and branch logic stay in exec_stage_md.

Test Plan:
- ALU/forward: forward_ae = 10, wb_data = 5, rdata2 = 3, alu_op = SUB → result = 2, md_busy = 0.
- Branch: fwd_a = 0xFFFFFFFF, fwd_b = 1:
  - br_type 100 → br_taken = 1.
  - br_type 110 → br_taken = 0.
  - Same with valid_i = 0 → 0.
- MUL/MULH: a = 0xFFFFFFFE (−2), b = 3:
  - MUL → 0xFFFFFFFA.
  - MULH → 0xFFFFFFFF.
  - MULHU → 0x00000002.
  - md_busy high exactly WIDTH+1 cycles, result valid in cycle WIDTH+2.
- DIV edge cases:
  - 7 / 0 → DIV = 0xFFFFFFFF, REM = 7.
  - 0x80000000 / −1 → DIV = 0x80000000, REM = 0.
  - −7 / 2 → DIV = −3, REM = −1.
- Flush/reset: flush at CALC cycle 10 → md_busy 0 next cycle, FSM IDLE, next DIVU 100/7 → 14. Asserting rst mid-CALC clears md_busy asynchronously.
- FAST_MUL_EN build: MUL 6 × 7 → 42 same cycle, md_busy never asserted; DIVU still WIDTH+2 cycles.
